// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then execute ALU / mul-div / nop / halt
// from the latched IR, producing the datapath's register-transfer strobes each clock.
module control_sequencer #(
   parameter int                NREGS   = 16,
   parameter int                OPW     = 5,
   parameter logic [OPW-1:0]    OP_MUL  = 5'b01110,
   parameter logic [OPW-1:0]    OP_DIV  = 5'b01111,
   parameter logic [OPW-1:0]    OP_NOP  = 5'b11010,
   parameter logic [OPW-1:0]    OP_HALT = 5'b11011
) (
   input  logic             Clock,
   input  logic             clear,
   input  logic [31:0]      IR,
   input  logic             Stop,
   output logic [NREGS-1:0] Rin,
   output logic [NREGS-1:0] Rout,
   output logic             PCout,
   output logic             PCin,
   output logic             IncPC,
   output logic             MARin,
   output logic             MDRin,
   output logic             MDRout,
   output logic             Read,
   output logic             IRin,
   output logic             Yin,
   output logic             Zin,
   output logic             Zlowout,
   output logic             Zhighout,
   output logic             HIin,
   output logic             LOin,
   output logic [OPW-1:0]   opcode,
   output logic             Run
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   state_t state_q, state_d;

   logic [OPW-1:0]   op;
   logic [3:0]       ra, rb, rc;
   logic             is_md, is_nop, is_halt;
   logic [NREGS-1:0] one;
   logic             unused_ir;

   assign op        = IR[31:32-OPW];
   assign ra        = IR[26:23];
   assign rb        = IR[22:19];
   assign rc        = IR[18:15];
   assign is_md     = (op == OP_MUL) || (op == OP_DIV);
   assign is_nop    = (op == OP_NOP);
   assign is_halt   = (op == OP_HALT);
   assign one       = {{(NREGS-1){1'b0}}, 1'b1};
   assign unused_ir = ^IR[14:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:  state_d = S_T0;
         S_T0:   state_d = Stop ? S_HALT : S_T1;
         S_T1:   state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3:   state_d = is_halt ? S_HALT : (is_nop ? S_T0 : S_T4);
         S_T4:   state_d = S_T5;
         S_T5:   state_d = is_md ? S_T6 : S_T0;
         S_T6:   state_d = S_T0;
         S_HALT: state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // clear wins over everything so a half-finished instruction is simply abandoned
   always_ff @(posedge Clock) begin
      if (clear) state_q <= S_RST;
      else       state_q <= state_d;
   end

   always_comb begin
      Rin      = '0;
      Rout     = '0;
      PCout    = 1'b0;
      PCin     = 1'b0;
      IncPC    = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      Read     = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      opcode   = '0;
      Run      = 1'b1;
      case (state_q)
         // a Stop in T0 leaves the PC untouched on the way to HALT
         S_T0: if (!Stop) begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: if (!is_nop && !is_halt) begin
            Rout = one << rb;
            Yin  = 1'b1;
         end
         S_T4: begin
            Rout   = one << rc;
            opcode = op;
            Zin    = 1'b1;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (is_md) LOin = 1'b1;
            else       Rin  = one << ra;
         end
         S_T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         S_HALT: Run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: the stimulus process queues hand-derived strobe vectors per cycle,
// a monitor pops and compares them mid-cycle and also watches bus-driver exclusivity.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        clear, Stop;
   logic [31:0] IR;
   logic [15:0] Rin, Rout;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
   logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, Run;
   logic [4:0]  opcode;

   control_sequencer dut (
      .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
      .Rin(Rin), .Rout(Rout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
      .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .HIin(HIin), .LOin(LOin), .opcode(opcode), .Run(Run)
   );

   always #5 Clock = ~Clock;

   // {Rin[51:36], Rout[35:20], fetch[19:12], exec[11:6], opcode[5:1], Run[0]}
   localparam logic [51:0] B_RUN   = 52'h1;
   localparam logic [51:0] B_LOIN  = 52'h1 << 6;
   localparam logic [51:0] B_HIIN  = 52'h1 << 7;
   localparam logic [51:0] B_ZHI   = 52'h1 << 8;
   localparam logic [51:0] B_ZLO   = 52'h1 << 9;
   localparam logic [51:0] B_ZIN   = 52'h1 << 10;
   localparam logic [51:0] B_YIN   = 52'h1 << 11;
   localparam logic [51:0] B_IRIN  = 52'h1 << 12;
   localparam logic [51:0] B_READ  = 52'h1 << 13;
   localparam logic [51:0] B_MDRO  = 52'h1 << 14;
   localparam logic [51:0] B_MDRI  = 52'h1 << 15;
   localparam logic [51:0] B_MARI  = 52'h1 << 16;
   localparam logic [51:0] B_INCPC = 52'h1 << 17;
   localparam logic [51:0] B_PCIN  = 52'h1 << 18;
   localparam logic [51:0] B_PCOUT = 52'h1 << 19;

   localparam logic [51:0] E_T0 = B_PCOUT | B_MARI | B_INCPC | B_ZIN | B_RUN;
   localparam logic [51:0] E_T1 = B_ZLO | B_PCIN | B_READ | B_MDRI | B_RUN;
   localparam logic [51:0] E_T2 = B_MDRO | B_IRIN | B_RUN;

   function automatic logic [51:0] rin(input int n);
      logic [51:0] b = 52'h1;
      return b << (36 + n);
   endfunction
   function automatic logic [51:0] rout(input int n);
      logic [51:0] b = 52'h1;
      return b << (20 + n);
   endfunction
   function automatic logic [51:0] opc(input logic [4:0] o);
      logic [51:0] b = {47'h0, o};
      return b << 1;
   endfunction

   typedef struct {
      logic [51:0] v;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   logic [51:0] act;
   assign act = {Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                 Yin, Zin, Zlowout, Zhighout, HIin, LOin, opcode, Run};

   always @(negedge Clock) begin
      exp_t e;
      int   drv;
      drv = $countones(Rout) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
      n_tot++;
      if (drv <= 1 && $countones(Rin) <= 1 && !(Rin != 0 && Rout != 0)) n_pass++;
      else $display("FAIL busexcl t=%0t drivers=%0d Rin=%h Rout=%h (need <=1 driver, one-hot, exclusive)",
                    $time, drv, Rin, Rout);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_tot++;
         if (act === e.v) n_pass++;
         else $display("FAIL %s t=%0t got=%h expected=%h", e.nm, $time, act, e.v);
      end
   end

   // queue the expectation for the current cycle, set inputs sampled at its closing edge
   task automatic cyc(input logic clr, input logic stp, input logic [51:0] e, input string nm);
      exp_t x;
      x.v = e;
      x.nm = nm;
      sb.push_back(x);
      clear = clr;
      Stop  = stp;
      @(posedge Clock);
      #1;
   endtask

   task automatic fetch(input string tag, input logic late_stop);
      cyc(1'b0, 1'b0,      E_T0, {tag, "_T0"});
      cyc(1'b0, late_stop, E_T1, {tag, "_T1"});
      cyc(1'b0, late_stop, E_T2, {tag, "_T2"});
   endtask

   task automatic alu_instr(input string tag, input logic [31:0] ir, input int ra, input int rb,
                            input int rc, input logic [4:0] op, input logic late_stop);
      IR = ir;
      fetch(tag, late_stop);
      cyc(1'b0, late_stop, rout(rb) | B_YIN | B_RUN,           {tag, "_T3"});
      cyc(1'b0, late_stop, rout(rc) | opc(op) | B_ZIN | B_RUN, {tag, "_T4"});
      cyc(1'b0, late_stop, rin(ra) | B_ZLO | B_RUN,            {tag, "_T5"});
   endtask

   task automatic md_instr(input string tag, input logic [31:0] ir, input int rb, input int rc,
                           input logic [4:0] op);
      IR = ir;
      fetch(tag, 1'b0);
      cyc(1'b0, 1'b0, rout(rb) | B_YIN | B_RUN,           {tag, "_T3"});
      cyc(1'b0, 1'b0, rout(rc) | opc(op) | B_ZIN | B_RUN, {tag, "_T4"});
      cyc(1'b0, 1'b0, B_ZLO | B_LOIN | B_RUN,             {tag, "_T5"});
      cyc(1'b0, 1'b0, B_ZHI | B_HIIN | B_RUN,             {tag, "_T6"});
   endtask

   task automatic halted(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 52'h0, {tag, "_halt"});
      cyc(1'b1, 1'b0, 52'h0,  {tag, "_clrhalt"});
      cyc(1'b0, 1'b0, B_RUN,  {tag, "_rst"});
   endtask

   initial begin
      IR    = 32'h0;
      clear = 1'b1;
      Stop  = 1'b0;
      @(posedge Clock);
      #1;
      // two clocks of clear, then release
      cyc(1'b1, 1'b0, B_RUN, "rst_a");
      cyc(1'b0, 1'b0, B_RUN, "rst_b");

      // shra R3,R2,R3 ; Stop pulsed outside T0 must be ignored
      alu_instr("shra", 32'h3191_8000, 3, 2, 3, 5'b00110, 1'b1);
      // add R5,R5,R5 : same register in every field
      alu_instr("add", 32'h1AAA_8000, 5, 5, 5, 5'b00011, 1'b0);
      // mul R2,R2,R0
      md_instr("mul", 32'h7110_0000, 2, 0, 5'b01110);
      // div R1,R4,R5
      md_instr("div", 32'h78A2_8000, 4, 5, 5'b01111);
      // nop: T3 silent, straight back to T0
      IR = 32'hD000_0000;
      fetch("nop", 1'b0);
      cyc(1'b0, 1'b0, B_RUN, "nop_T3");
      // ALU op right after nop, top registers
      alu_instr("and", 32'h57FF_8000, 15, 15, 15, 5'b01010, 1'b0);

      // halt instruction
      IR = 32'hD800_0000;
      fetch("halt", 1'b0);
      cyc(1'b0, 1'b0, B_RUN, "halt_T3");
      halted("hlt", 20);

      // Stop sampled in T0: no strobes, then HALT
      IR = 32'h3191_8000;
      cyc(1'b0, 1'b1, B_RUN, "stop_T0");
      halted("stp", 20);

      // clear in T4 abandons the instruction before Rin ever fires
      fetch("abort", 1'b0);
      cyc(1'b0, 1'b0, rout(2) | B_YIN | B_RUN,                "abort_T3");
      cyc(1'b1, 1'b0, rout(3) | opc(5'b00110) | B_ZIN | B_RUN, "abort_T4");
      cyc(1'b0, 1'b0, B_RUN,                                  "abort_rst");
      alu_instr("after", 32'h3191_8000, 3, 2, 3, 5'b00110, 1'b0);
      cyc(1'b0, 1'b0, E_T0, "final_T0");

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge Clock);
      #1;
      if (sb.size() != 0) begin
         n_tot++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
